// File: rtl/rld.sv
// Run-length expander: turns (run, magnitude) symbols into 64 zigzag coefficients per MCU.
// Optional feature: define RLD_ERR_CHECK_EN for sticky protocol-error detection on err.

// state | meaning
// IDLE  | waiting for a symbol (rrmg_ready=1)
// RUN   | emitting zeros from the run counter
// VAL   | emitting the registered magnitude
// FILL  | emitting zeros up to position 63 after EOB

module rld (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] rrrr,
   input  logic [7:0] magn,
   input  logic       isdc,
   input  logic       eoi,
   input  logic       rrmg_valid,
   output logic       rrmg_ready,
   output logic [7:0] data,
   output logic       data_valid,
   input  logic       data_ready,
   output logic       sob,
   output logic       eoi_out,
   output logic       err
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_VAL,
      ST_FILL
   } state_t;

   state_t     state_q, state_d;
   logic [5:0] pos_q, pos_d;
   logic [3:0] run_q, run_d;
   logic [7:0] magn_q, magn_d;
   logic       zero_only_q, zero_only_d;
   logic       eoi_q, eoi_d;
   logic       accept;
   logic       out_hs;
   logic       last_pos;
`ifdef RLD_ERR_CHECK_EN
   logic       err_q, err_d;
`endif

   assign rrmg_ready = (state_q == ST_IDLE);
   assign data_valid = (state_q != ST_IDLE);
   assign data       = (state_q == ST_VAL) ? magn_q : 8'd0;
   assign last_pos   = (pos_q == 6'd63);
   assign sob        = data_valid & (pos_q == 6'd0);
   assign eoi_out    = data_valid & last_pos & eoi_q;
   assign accept     = rrmg_valid & rrmg_ready;
   assign out_hs     = data_valid & data_ready;

`ifdef RLD_ERR_CHECK_EN
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      pos_d       = pos_q;
      run_d       = run_q;
      magn_d      = magn_q;
      zero_only_d = zero_only_q;
      eoi_d       = eoi_q;
`ifdef RLD_ERR_CHECK_EN
      err_d       = err_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               eoi_d  = eoi;
               magn_d = magn;
               if (isdc) begin
                  state_d = ST_VAL;
`ifdef RLD_ERR_CHECK_EN
                  if (pos_q != 6'd0) begin
                     err_d = 1'b1;
                     pos_d = 6'd0;
                  end
`endif
               end else begin
`ifdef RLD_ERR_CHECK_EN
                  if (pos_q == 6'd0) begin
                     err_d = 1'b1;
                  end
`endif
                  if (rrrr == 4'd0) begin
                     state_d = (magn == 8'd0) ? ST_FILL : ST_VAL;
                  end else begin
                     // run_q holds zeros-remaining minus one; ZRL therefore loads 15 for 16 zeros
                     state_d     = ST_RUN;
                     zero_only_d = (magn == 8'd0);
                     run_d       = ((magn == 8'd0) && (rrrr == 4'd15)) ? 4'd15 : (rrrr - 4'd1);
                  end
               end
            end
         end
         ST_RUN: begin
            if (out_hs) begin
               if (run_q == 4'd0) begin
                  state_d = zero_only_q ? ST_IDLE : ST_VAL;
               end else begin
                  run_d = run_q - 4'd1;
               end
            end
         end
         ST_VAL: begin
            if (out_hs) begin
               state_d = ST_IDLE;
            end
         end
         ST_FILL: begin
            state_d = ST_FILL;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Position 63 closes the block regardless of what the current symbol still owes
      if (out_hs) begin
         pos_d = pos_q + 6'd1;
         if (last_pos) begin
            state_d = ST_IDLE;
            run_d   = 4'd0;
`ifdef RLD_ERR_CHECK_EN
            if ((state_q == ST_RUN) && ((run_q != 4'd0) || !zero_only_q)) begin
               err_d = 1'b1;
            end
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         pos_q       <= 6'd0;
         run_q       <= 4'd0;
         magn_q      <= 8'd0;
         zero_only_q <= 1'b0;
         eoi_q       <= 1'b0;
`ifdef RLD_ERR_CHECK_EN
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         pos_q       <= pos_d;
         run_q       <= run_d;
         magn_q      <= magn_d;
         zero_only_q <= zero_only_d;
         eoi_q       <= eoi_d;
`ifdef RLD_ERR_CHECK_EN
         err_q       <= err_d;
`endif
      end
   end

endmodule

// File: tb/tb_rld.sv
// Self-checking bench for rld: table vectors, directed corner sequences and a randomized
// MCU stream compared against a list-based expansion model.
`timescale 1ns/1ps

module tb_rld;

`ifdef RLD_ERR_CHECK_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif
   localparam int MAX_CYC = 20000;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] rrrr;
   logic [7:0] magn;
   logic       isdc;
   logic       eoi;
   logic       rrmg_valid;
   logic       rrmg_ready;
   logic [7:0] data;
   logic       data_valid;
   logic       data_ready;
   logic       sob;
   logic       eoi_out;
   logic       err;

   typedef struct packed {
      logic       isdc;
      logic       eoi;
      logic [3:0] rrrr;
      logic [7:0] magn;
   } sym_t;

   typedef struct packed {
      logic [7:0] data;
      logic       sob;
      logic       eoi_out;
   } coef_t;

   typedef struct {
      int             nsym;
      sym_t [5:0]     s;
      int             exp_cnt;
      int             exp_sum;
      bit             exp_trunc;
   } vec_t;

   sym_t  sym_q[$];
   coef_t exp_q[$];
   coef_t cap_q[$];
   bit    exp_err;
   vec_t  vecs[6];
   int    n_chk  = 0;
   int    n_fail = 0;
   int    sum;
   int    eoi_cnt;

   rld dut (
      .clk        (clk),
      .rst        (rst),
      .rrrr       (rrrr),
      .magn       (magn),
      .isdc       (isdc),
      .eoi        (eoi),
      .rrmg_valid (rrmg_valid),
      .rrmg_ready (rrmg_ready),
      .data       (data),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .sob        (sob),
      .eoi_out    (eoi_out),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic sym_t mk(input logic d, input logic e, input int r, input int m);
      sym_t s;
      s.isdc = d;
      s.eoi  = e;
      s.rrrr = r[3:0];
      s.magn = m[7:0];
      return s;
   endfunction

   // Each symbol becomes a list of coefficients; a block ends after position 63 and
   // whatever is left of the current list is dropped.
   task automatic model();
      int pos = 0;
      int zeros;
      int items;
      bit has_val;
      coef_t c;
      exp_q.delete();
      exp_err = 1'b0;
      foreach (sym_q[i]) begin
         if (sym_q[i].isdc) begin
            if (ERR_EN && pos != 0) begin
               exp_err = 1'b1;
               pos     = 0;
            end
            zeros   = 0;
            has_val = 1'b1;
         end else begin
            if (ERR_EN && pos == 0) exp_err = 1'b1;
            if (sym_q[i].magn != 0) begin
               zeros   = sym_q[i].rrrr;
               has_val = 1'b1;
            end else if (sym_q[i].rrrr == 15) begin
               zeros   = 16;
               has_val = 1'b0;
            end else if (sym_q[i].rrrr == 0) begin
               zeros   = 64 - pos;
               has_val = 1'b0;
            end else begin
               zeros   = sym_q[i].rrrr;
               has_val = 1'b0;
            end
         end
         items = zeros + (has_val ? 1 : 0);
         for (int k = 0; k < items; k++) begin
            c.data    = (k == zeros) ? sym_q[i].magn : 8'd0;
            c.sob     = (pos == 0);
            c.eoi_out = (pos == 63) && sym_q[i].eoi;
            exp_q.push_back(c);
            if (pos == 63) begin
               pos = 0;
               if (ERR_EN && k < items - 1) exp_err = 1'b1;
               break;
            end
            pos++;
         end
      end
   endtask

   task automatic reset_dut();
      rst        = 1'b1;
      rrmg_valid = 1'b0;
      data_ready = 1'b0;
      isdc       = 1'b0;
      eoi        = 1'b0;
      rrrr       = 4'd0;
      magn       = 8'd0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // ready_mode: 0 always ready, 1 random, 2 toggling 1010...
   task automatic run_stream(input int ready_mode, input bit rand_valid, input string tag);
      int    idx = 0;
      int    cyc = 0;
      int    extra = 0;
      bit    stalled = 1'b0;
      coef_t held;
      coef_t c;
      model();
      cap_q.delete();
      while ((idx < sym_q.size() || cap_q.size() < exp_q.size()) && cyc < MAX_CYC) begin
         if (idx < sym_q.size() && (!rand_valid || $urandom_range(0, 3) != 0)) begin
            {isdc, eoi, rrrr, magn} = sym_q[idx];
            rrmg_valid = 1'b1;
         end else begin
            rrmg_valid = 1'b0;
         end
         case (ready_mode)
            0:       data_ready = 1'b1;
            1:       data_ready = ($urandom_range(0, 2) != 0);
            default: data_ready = ~cyc[0];
         endcase
         @(negedge clk);
         if (stalled) begin
            check({tag, " stall valid"}, 32'(data_valid), 32'd1);
            check({tag, " stall hold"}, 32'({data, sob, eoi_out}), 32'(held));
         end
         stalled = data_valid && !data_ready;
         held    = {data, sob, eoi_out};
         if (rrmg_valid && rrmg_ready) idx++;
         if (data_valid && data_ready) begin
            c = {data, sob, eoi_out};
            cap_q.push_back(c);
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      check({tag, " within cycle budget"}, 32'(cyc < MAX_CYC), 32'd1);
      rrmg_valid = 1'b0;
      data_ready = 1'b1;
      for (int i = 0; i < 70; i++) begin
         @(negedge clk);
         if (data_valid) extra++;
         @(posedge clk);
         #1;
      end
      check({tag, " extra outputs"}, 32'(extra), 32'd0);
      check({tag, " coef count"}, 32'(cap_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
         check($sformatf("%s coef %0d", tag, i), 32'(cap_q[i]), 32'(exp_q[i]));
      check({tag, " err"}, 32'(err), 32'(exp_err));
   endtask

   task automatic set_vec(input int i, input int n, input int cnt, input int s, input bit tr);
      vecs[i].nsym      = n;
      vecs[i].exp_cnt   = cnt;
      vecs[i].exp_sum   = s;
      vecs[i].exp_trunc = tr;
      vecs[i].s         = '0;
   endtask

   initial begin
      set_vec(0, 3, 64, 8, 1'b0);
      vecs[0].s[0] = mk(1, 0, 0, 5);   vecs[0].s[1] = mk(0, 0, 2, 3);
      vecs[0].s[2] = mk(0, 0, 0, 0);
      set_vec(1, 6, 64, 1, 1'b0);
      vecs[1].s[0] = mk(1, 0, 0, 1);   vecs[1].s[1] = mk(0, 0, 15, 0);
      vecs[1].s[2] = mk(0, 0, 15, 0);  vecs[1].s[3] = mk(0, 0, 15, 0);
      vecs[1].s[4] = mk(0, 0, 14, 0);  vecs[1].s[5] = mk(0, 0, 0, 0);
      set_vec(2, 2, 64, 7, 1'b0);
      vecs[2].s[0] = mk(1, 0, 9, 7);   vecs[2].s[1] = mk(0, 0, 0, 0);
      set_vec(3, 3, 64, 11, 1'b0);
      vecs[3].s[0] = mk(1, 0, 0, 2);   vecs[3].s[1] = mk(0, 0, 15, 9);
      vecs[3].s[2] = mk(0, 0, 0, 0);
      set_vec(4, 5, 64, 3, 1'b1);
      vecs[4].s[0] = mk(1, 0, 0, 3);   vecs[4].s[1] = mk(0, 0, 15, 0);
      vecs[4].s[2] = mk(0, 0, 15, 0);  vecs[4].s[3] = mk(0, 0, 15, 0);
      vecs[4].s[4] = mk(0, 0, 15, 4);
      set_vec(5, 6, 64, 400, 1'b0);
      vecs[5].s[0] = mk(1, 1, 0, 255); vecs[5].s[1] = mk(0, 1, 0, 128);
      vecs[5].s[2] = mk(0, 1, 15, 0);  vecs[5].s[3] = mk(0, 1, 15, 0);
      vecs[5].s[4] = mk(0, 1, 15, 0);  vecs[5].s[5] = mk(0, 1, 13, 17);

      // Reset state
      reset_dut();
      @(negedge clk);
      check("reset rrmg_ready", 32'(rrmg_ready), 32'd1);
      check("reset data_valid", 32'(data_valid), 32'd0);
      check("reset data", 32'(data), 32'd0);
      check("reset sob", 32'(sob), 32'd0);
      check("reset eoi_out", 32'(eoi_out), 32'd0);
      check("reset err", 32'(err), 32'd0);

      // Latency: DC accepted at one edge, coefficient visible right after it
      @(posedge clk);
      #1;
      {isdc, eoi, rrrr, magn} = mk(1, 0, 0, 5);
      rrmg_valid = 1'b1;
      data_ready = 1'b1;
      @(negedge clk);
      check("lat pre valid", 32'(data_valid), 32'd0);
      @(posedge clk);
      #1 rrmg_valid = 1'b0;
      @(negedge clk);
      check("lat data_valid", 32'(data_valid), 32'd1);
      check("lat data", 32'(data), 32'd5);
      check("lat sob", 32'(sob), 32'd1);
      check("lat rrmg_ready", 32'(rrmg_ready), 32'd0);

      // Table vectors
      for (int i = 0; i < 6; i++) begin
         reset_dut();
         sym_q.delete();
         for (int k = 0; k < vecs[i].nsym; k++) sym_q.push_back(vecs[i].s[k]);
         run_stream(i % 3, i[0], $sformatf("vec%0d", i));
         sum = 0;
         foreach (cap_q[k]) sum += cap_q[k].data;
         check($sformatf("vec%0d count", i), 32'(cap_q.size()), 32'(vecs[i].exp_cnt));
         check($sformatf("vec%0d sum", i), 32'(sum), 32'(vecs[i].exp_sum));
         check($sformatf("vec%0d err", i), 32'(err), 32'(ERR_EN & vecs[i].exp_trunc));
      end

      // Two full MCUs of 63 (0,k) symbols; only the second carries eoi
      reset_dut();
      sym_q.delete();
      for (int m = 0; m < 2; m++) begin
         sym_q.push_back(mk(1, m, 0, 100 + m));
         for (int k = 1; k < 64; k++) sym_q.push_back(mk(0, m, 0, k));
      end
      sym_q.push_back(mk(1, 0, 0, 42));
      sym_q.push_back(mk(0, 0, 0, 0));
      run_stream(0, 1'b0, "full63");
      eoi_cnt = 0;
      foreach (cap_q[k]) eoi_cnt += cap_q[k].eoi_out;
      check("full63 eoi_out count", 32'(eoi_cnt), 32'd1);
      if (cap_q.size() == 192) begin
         check("full63 eoi_out at 127", 32'(cap_q[127].eoi_out), 32'd1);
         check("full63 second DC", 32'(cap_q[64]), 32'({8'd101, 1'b1, 1'b0}));
      end else begin
         check("full63 size", 32'(cap_q.size()), 32'd192);
      end

      // DC arriving at position 10, then reset in the middle of a run
      reset_dut();
      sym_q.delete();
      sym_q.push_back(mk(1, 0, 0, 1));
      for (int k = 2; k <= 10; k++) sym_q.push_back(mk(0, 0, 0, k));
      sym_q.push_back(mk(1, 0, 0, 8'h77));
      sym_q.push_back(mk(0, 0, 0, 0));
      run_stream(0, 1'b0, "dc_mid");
      check("dc_mid count", 32'(cap_q.size()), ERR_EN ? 32'd74 : 32'd64);
      if (cap_q.size() > 10) begin
         check("dc_mid data", 32'(cap_q[10].data), 32'h77);
         check("dc_mid sob", 32'(cap_q[10].sob), 32'(ERR_EN));
      end else begin
         check("dc_mid short", 32'(cap_q.size()), 32'd74);
      end
      check("dc_mid err", 32'(err), 32'(ERR_EN));

      data_ready = 1'b1;
      {isdc, eoi, rrrr, magn} = mk(1, 0, 0, 1);
      rrmg_valid = 1'b1;
      @(posedge clk);
      #1 rrmg_valid = 1'b0;
      @(posedge clk);
      #1;
      {isdc, eoi, rrrr, magn} = mk(0, 0, 15, 0);
      rrmg_valid = 1'b1;
      @(posedge clk);
      #1 rrmg_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("mid-run valid", 32'(data_valid), 32'd1);
      check("mid-run data", 32'(data), 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst data_valid", 32'(data_valid), 32'd0);
      check("rst err", 32'(err), 32'd0);
      check("rst rrmg_ready", 32'(rrmg_ready), 32'd1);
      eoi_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (data_valid) eoi_cnt++;
      end
      check("rst no further output", 32'(eoi_cnt), 32'd0);

      // Randomized MCU stream with random valid/ready
      reset_dut();
      sym_q.delete();
      for (int m = 0; m < 25; m++) begin
         bit e;
         int p;
         int t;
         int r;
         e = ($urandom_range(0, 3) == 0);
         p = 1;
         sym_q.push_back(mk(1, e, $urandom_range(0, 15), $urandom_range(0, 255)));
         while (p < 64) begin
            t = $urandom_range(0, 19);
            r = $urandom_range(0, 6);
            if (t < 14) begin
               sym_q.push_back(mk(0, e, r, $urandom_range(1, 255)));
               p += r + 1;
            end else if (t < 16) begin
               sym_q.push_back(mk(0, e, 15, 0));
               p += 16;
            end else if (t < 17) begin
               r = $urandom_range(1, 14);
               sym_q.push_back(mk(0, e, r, 0));
               p += r;
            end else begin
               sym_q.push_back(mk(0, e, 0, 0));
               p = 64;
            end
         end
      end
      run_stream(1, 1'b1, "rand");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rld.md
RLD -- requirements
Module: rld

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: rrrr  input  4  zero-run length of the incoming symbol.
REQ-004 SHALL have port: magn  input  8  coefficient value of the incoming symbol.
REQ-005 SHALL have port: isdc  input  1  incoming symbol is the DC (first) symbol of an MCU.
REQ-006 SHALL have port: eoi  input  1  incoming symbol belongs to the last MCU of the image.
REQ-007 SHALL have port: rrmg_valid  input  1  symbol present.
REQ-008 SHALL have port: rrmg_ready  output  1  symbol accepted when rrmg_valid & rrmg_ready at a clk edge.
REQ-009 SHALL have port: data  output  8  expanded coefficient, zigzag order.
REQ-010 SHALL have port: data_valid  output  1  data present.
REQ-011 SHALL have port: data_ready  input  1  downstream accepts data when data_valid & data_ready.
REQ-012 SHALL have port: sob  output  1  data is position 0 of an MCU, qualified by data_valid.
REQ-013 SHALL have port: eoi_out  output  1  data is position 63 of the last MCU, qualified by data_valid.
REQ-014 SHALL have port: err  output  1  sticky protocol-error flag.

Function
REQ-015 SHALL expand each 8x8 MCU's symbol stream into exactly 64 coefficients; 6-bit position counter pos, 0..63, wraps to 0 after 63 is emitted.
REQ-016 SHALL implement FSM IDLE, RUN, VAL, FILL; rrmg_ready=1 only in IDLE; data_valid=1 only in RUN, VAL, FILL.
REQ-017 SHALL decode the accepted symbol in IDLE as follows.
- isdc=1: go to VAL with data=magn; rrrr is ignored.
- magn!=0, rrrr>0: go to RUN with 4-bit run counter = rrrr, then VAL.
- magn!=0, rrrr=0: go to VAL.
- (15,0) ZRL: go to RUN emitting 16 zeros, then IDLE.
- (0,0) EOB: go to FILL.
REQ-018 SHALL drive data=0 in RUN and FILL, and the registered magn in VAL.
REQ-019 SHALL advance pos and the run counter only on an output handshake; a stalled output holds data, data_valid, sob and eoi_out stable.
REQ-020 SHALL present the first coefficient in the cycle after symbol acceptance (latency 1); throughput is one coefficient per cycle in RUN/FILL, plus one IDLE bubble per symbol.
REQ-021 SHALL leave FILL after emitting pos 63; an EOB accepted at pos 0 of a non-DC context SHALL emit 64 zeros.
REQ-022 SHALL treat emission of pos 63 in any state as end of block: pos becomes 0 and the FSM goes to IDLE; the remaining run or value is discarded.
REQ-023 SHALL drive sob = data_valid & (pos==0).
REQ-024 SHALL latch eoi on acceptance of each MCU's symbols and drive eoi_out on that MCU's pos-63 coefficient.

Reset
REQ-025 SHALL, on rst=1 at a clk edge, force state IDLE, pos=0, run counter=0, eoi latch=0, data=0, data_valid=0, err=0; rrmg_ready=1 from the first cycle after reset.
REQ-026 SHALL abort any in-progress MCU on reset mid-operation without emitting further coefficients.

Configuration
REQ-027 SHALL, with RLD_ERR_CHECK_EN defined, set err (sticky until rst) on any of:
- isdc=1 accepted with pos!=0; the partial MCU is abandoned, pos is forced to 0 and the symbol is decoded as DC;
- isdc=0 accepted with pos=0;
- a run truncated by REQ-022.
REQ-028 SHALL, without RLD_ERR_CHECK_EN, tie err to 0 and decode isdc/pos mismatches per REQ-017 unchanged; truncation still applies.

Verification
REQ-029 SHALL cover: DC(0,5), (2,3), EOB -> 64 coefficients 5,0,0,3, then 60 zeros; sob on the first; latency 1 cycle.
REQ-030 SHALL cover: DC(0,1), (15,0), (15,0), (15,0), (14,0)+EOB-at-63 -> 1 then 63 zeros; no extra output; err=0.
REQ-031 SHALL cover: 63 nonzero symbols (0,k) after DC, last at pos 63 with no EOB -> next DC accepted at pos 0; eoi_out only when eoi was set.
REQ-032 SHALL cover: data_ready toggled 1010... during FILL -> data held stable on stalls; 64 handshakes exactly.
REQ-033 SHALL cover: with RLD_ERR_CHECK_EN, DC at pos 10 -> err=1, next coefficient emitted at pos 0 with sob=1; rst pulse mid-RUN -> data_valid=0 next cycle, err=0.
